edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Multi-channel edge-event scheduler. Detects edges on CHANNELS synchronous input
//  signals, latches each as a pending event, and serialises them onto one
//  valid/ready event port via round-robin arbitration. Sits between raw
//  control/status lines and the event-consuming logic (interrupt/sequence control).
// PARAMETERS
//  CHANNELS  4  number of monitored input signals (2..16)
//  IDX_W     2  width of channel index; 2**IDX_W >= CHANNELS required
// PORTS
//  in_clock           input   1         single clock, all logic on rising edge
//  in_reset           input   1         synchronous, active-high reset
//  in_signal          input   CHANNELS  monitored lines, synchronous to in_clock
//  in_ready           input   1         consumer accepts event this cycle
//  in_clear_overrun   input   1         clears all out_overrun bits
//  out_valid          output  1         event present on out_channel/out_rising
//  out_channel        output  IDX_W     index of channel owning current event
//  out_rising         output  1         1 = rising-edge event, 0 = falling-edge event
//  out_pending        output  CHANNELS  pending (not yet issued) events
//  out_overrun        output  CHANNELS  sticky: edge lost because channel already pending
// BEHAVIOUR
//  - Reset: out_valid=0, out_channel=0, out_rising=1, out_pending=0, out_overrun=0,
//    RR pointer=CHANNELS-1 (ch0 highest priority first); prev[] <= in_signal, so
//    a line held high through reset produces no event.
//  - Edge detect: prev[c] registered every cycle; rise[c]=in_signal[c]&~prev[c].
//  - Pending: rise[c] sets pending[c] at that edge. Latency: line high before edge t
//    -> pending at t -> out_valid=1 at t+1 (one event, regardless of pulse width).
//  - FSM IDLE: out_valid=0; if pending!=0, grant first set bit searching from
//    pointer+1 with wrap; load out_channel, clear its pending bit, pointer<=grant,
//    -> VALID.
//  - FSM VALID: out_valid=1, out_channel/out_rising stable until in_ready=1.
//    On handshake: if other pending, grant next in same cycle (back-to-back,
//    1 event/cycle, stay VALID); else -> IDLE.
//  - Simultaneous: edge on ch c in the cycle ch c is granted -> pending[c] re-set,
//    new event, no overrun. Edge on ch c while pending[c]=1 -> overrun[c]<=1, no
//    second event.
//  - in_clear_overrun with new overrun same cycle -> set wins.
//  - Reset mid-operation: in-flight and pending events discarded, state as above.
//  - Unused index values (>=CHANNELS) never driven.
// CONFIGURATION
//  EDGE_ARB_FALLING_EN defined: falling edges (~in_signal&prev) also events; per
//    channel separate rise/fall pending bits, out_pending = OR of both; rise has
//    priority over fall within a channel; out_rising reports polarity.
//  Not defined: only rising edges detected; out_rising tied 1; falling logic absent.
// TESTING
//  1 in_signal=4'b0010 held through reset, released -> out_valid=0 for 10 cycles.
//  2 rise ch2, in_ready=1 -> out_pending[2]=1 next edge, then out_valid=1,
//    out_channel=2 for exactly 1 cycle.
//  3 rise ch0,ch1,ch3 same cycle, in_ready=1 -> channels 0,1,3 on consecutive
//    cycles, out_valid then 0.
//  4 in_ready=0 with ch2 event held; ch2 pulses again twice -> out_overrun[2]=1,
//    only one further ch2 event; in_clear_overrun=1 -> out_overrun=0.
//  5 ch0 rising every 2nd cycle, single ch1 rise -> ch1 granted within 2 grants.
//  6 EDGE_ARB_FALLING_EN: ch1 1->0 -> event ch1 with out_rising=0; without macro
//    -> no event.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Multi-channel edge-event scheduler. Watches CHANNELS synchronous lines,
// latches every detected edge as a pending event and serialises the pending
// events onto a single valid/ready port using round-robin arbitration.
//
// Build option:
//   EDGE_ARB_FALLING_EN  when defined, falling edges are events as well. Each
//                        channel then keeps separate rise/fall pending bits.
//                        Rise wins over fall inside one channel, and
//                        out_rising reports the polarity. When undefined,
//                        only rising edges are seen and out_rising is
//                        constant 1.
//
// Parameters:
//   CHANNELS  number of monitored lines (2..16)
//   IDX_W     channel index width, 2**IDX_W >= CHANNELS
//
// Ports:
//   in_clock          clock, all logic on the rising edge
//   in_reset          synchronous active-high reset
//   in_signal         monitored lines (synchronous to in_clock)
//   in_ready          consumer accepts the presented event this cycle
//   in_clear_overrun  clears every sticky overrun bit
//   out_valid         an event is presented on out_channel/out_rising
//   out_channel       channel that owns the presented event
//   out_rising        1 = rising-edge event, 0 = falling-edge event
//   out_pending       per-channel latched events not yet issued
//   out_overrun       sticky per-channel flag: an edge was lost because the
//                     same event was already pending
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                in_clock,
  input  logic                in_reset,
  input  logic [CHANNELS-1:0] in_signal,
  input  logic                in_ready,
  input  logic                in_clear_overrun,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_channel,
  output logic                out_rising,
  output logic [CHANNELS-1:0] out_pending,
  output logic [CHANNELS-1:0] out_overrun
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_VALID  = 1'b1;
  // The pointer holds the last granted channel. Starting at the top channel
  // makes channel 0 the first candidate after reset.
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(CHANNELS - 1);

  generate
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
      $error("edge_event_arbiter: CHANNELS must be in 2..16");
    end
    if ((1 << IDX_W) < CHANNELS) begin : g_bad_idx_w
      $error("edge_event_arbiter: IDX_W too small for CHANNELS");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] prev_reg;
  logic [CHANNELS-1:0] pend_rise_reg;
  logic [CHANNELS-1:0] pend_rise_next;
  logic [CHANNELS-1:0] overrun_reg;
  logic [CHANNELS-1:0] overrun_next;
  logic [0:0]          state_reg;
  logic [0:0]          state_next;
  logic [IDX_W-1:0]    ptr_reg;
  logic [IDX_W-1:0]    ptr_next;
  logic [IDX_W-1:0]    channel_reg;
  logic [IDX_W-1:0]    channel_next;
`ifdef EDGE_ARB_FALLING_EN
  logic [CHANNELS-1:0] pend_fall_reg;
  logic [CHANNELS-1:0] pend_fall_next;
  logic                rising_reg;
  logic                rising_next;
`endif

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] rise_evt;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] overrun_set;
  logic [CHANNELS-1:0] grant_sel;
  logic [CHANNELS-1:0] grant_onehot;
  logic [CHANNELS-1:0] clr_rise;
`ifdef EDGE_ARB_FALLING_EN
  logic [CHANNELS-1:0] fall_evt;
  logic [CHANNELS-1:0] clr_fall;
  logic                grant_rise;
`endif

  logic                hi_found;
  logic                lo_found;
  logic [IDX_W-1:0]    hi_idx;
  logic [IDX_W-1:0]    lo_idx;
  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic                slot_free;
  logic                do_grant;

  // The output slot can take a new event when nothing is presented or the
  // presented one is being accepted in this very cycle (back-to-back issue).
  assign slot_free = (state_reg == ST_IDLE) || in_ready;
  assign do_grant  = slot_free && grant_found;

`ifdef EDGE_ARB_FALLING_EN
  // Within the granted channel a pending rise is served before a fall.
  assign grant_rise = |(grant_sel & pend_rise_reg);
`endif

  // -------------------------------------------------------------------------
  // Per-channel edge detection and pending/overrun bookkeeping
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign rise_evt[gi]     = in_signal[gi] & ~prev_reg[gi];
      assign grant_sel[gi]    = (grant_idx == IDX_W'(gi));
      assign grant_onehot[gi] = do_grant & grant_sel[gi];

`ifdef EDGE_ARB_FALLING_EN
      assign fall_evt[gi] = ~in_signal[gi] & prev_reg[gi];
      assign clr_rise[gi] = grant_onehot[gi] & grant_rise;
      assign clr_fall[gi] = grant_onehot[gi] & ~grant_rise;
      assign req[gi]      = pend_rise_reg[gi] | pend_fall_reg[gi];

      assign pend_fall_next[gi] = fall_evt[gi] |
                                  (pend_fall_reg[gi] & ~clr_fall[gi]);

      // An edge is lost only if its bit stays pending; an edge arriving in
      // the cycle its own bit is granted simply re-arms that bit.
      assign overrun_set[gi] = (rise_evt[gi] & pend_rise_reg[gi] & ~clr_rise[gi]) |
                               (fall_evt[gi] & pend_fall_reg[gi] & ~clr_fall[gi]);
`else
      assign clr_rise[gi]    = grant_onehot[gi];
      assign req[gi]         = pend_rise_reg[gi];
      assign overrun_set[gi] = rise_evt[gi] & pend_rise_reg[gi] & ~clr_rise[gi];
`endif

      assign pend_rise_next[gi] = rise_evt[gi] |
                                  (pend_rise_reg[gi] & ~clr_rise[gi]);

      // A new overrun in the same cycle as a clear request wins.
      assign overrun_next[gi] = overrun_set[gi] |
                                (overrun_reg[gi] & ~in_clear_overrun);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search: the first requesting channel strictly above the
  // pointer wins; otherwise the lowest requester at or below it (wrap).
  // Descending loops let the lowest matching index be the last assignment.
  // -------------------------------------------------------------------------
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (req[c]) begin
        if (c > int'(ptr_reg)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(c);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(c);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // -------------------------------------------------------------------------
  // Output FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    channel_next = channel_reg;
`ifdef EDGE_ARB_FALLING_EN
    rising_next  = rising_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (do_grant) begin
          state_next   = ST_VALID;
          ptr_next     = grant_idx;
          channel_next = grant_idx;
`ifdef EDGE_ARB_FALLING_EN
          rising_next  = grant_rise;
`endif
        end
      end
      ST_VALID: begin
        // Presented event is held stable until accepted.
        if (in_ready) begin
          if (do_grant) begin
            ptr_next     = grant_idx;
            channel_next = grant_idx;
`ifdef EDGE_ARB_FALLING_EN
            rising_next  = grant_rise;
`endif
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge in_clock) begin
    // Sampling the lines during reset means a line already high (or low)
    // at release produces no spurious edge.
    prev_reg <= in_signal;
    if (in_reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= PTR_RESET;
      channel_reg   <= '0;
      pend_rise_reg <= '0;
      overrun_reg   <= '0;
`ifdef EDGE_ARB_FALLING_EN
      pend_fall_reg <= '0;
      rising_reg    <= 1'b1;
`endif
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      channel_reg   <= channel_next;
      pend_rise_reg <= pend_rise_next;
      overrun_reg   <= overrun_next;
`ifdef EDGE_ARB_FALLING_EN
      pend_fall_reg <= pend_fall_next;
      rising_reg    <= rising_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid   = (state_reg == ST_VALID);
  assign out_channel = channel_reg;
  assign out_pending = req;
  assign out_overrun = overrun_reg;
`ifdef EDGE_ARB_FALLING_EN
  assign out_rising  = rising_reg;
`else
  assign out_rising  = 1'b1;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Self-checking bench for edge_event_arbiter (CHANNELS=4, IDX_W=2).
// Expected events {rising, channel} are queued when stimulus is driven and
// compared by a monitor on every accepted handshake. Works for both builds
// (EDGE_ARB_FALLING_EN defined or not).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_edge_event_arbiter;

  localparam int CHANNELS = 4;
  localparam int IDX_W    = 2;

  logic                clk;
  logic                rst;
  logic [CHANNELS-1:0] sig;
  logic                ready;
  logic                clr_ovr;
  logic                valid;
  logic [IDX_W-1:0]    chan;
  logic                rising;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overrun;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [IDX_W:0] exp_q[$];
  logic [IDX_W:0] mon_e;

  edge_event_arbiter #(
    .CHANNELS(CHANNELS),
    .IDX_W   (IDX_W)
  ) dut (
    .in_clock        (clk),
    .in_reset        (rst),
    .in_signal       (sig),
    .in_ready        (ready),
    .in_clear_overrun(clr_ovr),
    .out_valid       (valid),
    .out_channel     (chan),
    .out_rising      (rising),
    .out_pending     (pending),
    .out_overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input int ch, input logic rise);
    logic [IDX_W:0] e;
    e = {rise, IDX_W'(ch)};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    repeat (4) tick();
    while ((exp_q.size() != 0 || valid) && n < 64) begin
      tick();
      n++;
    end
    check_val({tag, "_drained"}, exp_q.size(), 0);
    check_val({tag, "_idle"}, valid, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"},   valid,   0);
    check_val({tag, "_channel"}, chan,    0);
    check_val({tag, "_rising"},  rising,  1);
    check_val({tag, "_pending"}, pending, 0);
    check_val({tag, "_overrun"}, overrun, 0);
  endtask

  // Scoreboard monitor: one line per accepted event.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      check_val("sb_has_entry", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        $display("evt  t=%0t ch=%0d rising=%0d exp_ch=%0d exp_rising=%0d",
                 $time, chan, rising, mon_e[IDX_W-1:0], mon_e[IDX_W]);
        check_val("evt_channel", chan, mon_e[IDX_W-1:0]);
        check_val("evt_rising", rising, mon_e[IDX_W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    sig     = 4'b0010;
    ready   = 1'b1;
    clr_ovr = 1'b0;

    // Line held high through reset: no event after release.
    repeat (3) tick();
    check_reset_state("rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("t1_no_event", valid, 0);
    end
    check_val("t1_pending", pending, 0);

    // ch1 falls: an event only when falling edges are enabled.
    sig = 4'b0000;
`ifdef EDGE_ARB_FALLING_EN
    push_evt(1, 1'b0);
`endif
    wait_drain("t6");

    // Fresh reset so channel 0 has first priority.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("rst2");

    // Three simultaneous rises served on consecutive cycles.
    push_evt(0, 1'b1);
    push_evt(1, 1'b1);
    push_evt(3, 1'b1);
    sig = 4'b1011;
    tick();
    check_val("t3_pending", pending, 4'b1011);
    check_val("t3_not_yet", valid, 0);
    tick();
    check_val("t3_v0", valid, 1);
    check_val("t3_c0", chan, 0);
    tick();
    check_val("t3_v1", valid, 1);
    check_val("t3_c1", chan, 1);
    tick();
    check_val("t3_v2", valid, 1);
    check_val("t3_c3", chan, 3);
    tick();
    check_val("t3_done", valid, 0);
    sig = 4'b0000;
`ifdef EDGE_ARB_FALLING_EN
    push_evt(0, 1'b0);
    push_evt(1, 1'b0);
    push_evt(3, 1'b0);
`endif
    wait_drain("t3");

    // Single rise on ch2: pending next edge, valid exactly one cycle.
    push_evt(2, 1'b1);
    sig = 4'b0100;
    tick();
    check_val("t2_pending", pending, 4'b0100);
    check_val("t2_not_yet", valid, 0);
    tick();
    check_val("t2_valid", valid, 1);
    check_val("t2_channel", chan, 2);
    check_val("t2_rising", rising, 1);
    check_val("t2_pend_clr", pending, 0);
    tick();
    check_val("t2_one_cycle", valid, 0);
    sig = 4'b0000;
`ifdef EDGE_ARB_FALLING_EN
    push_evt(2, 1'b0);
`endif
    wait_drain("t2");

    // Consumer stalled: repeated ch2 pulses overrun, one further event only.
    ready = 1'b0;
    push_evt(2, 1'b1);
    push_evt(2, 1'b1);
`ifdef EDGE_ARB_FALLING_EN
    push_evt(2, 1'b0);
`endif
    sig = 4'b0100; tick();
    sig = 4'b0000; tick();
    check_val("t4_held_valid", valid, 1);
    check_val("t4_held_ch", chan, 2);
    sig = 4'b0100; tick();
    sig = 4'b0000; tick();
`ifndef EDGE_ARB_FALLING_EN
    check_val("t4_no_ovr_yet", overrun, 0);
`endif
    sig = 4'b0100; tick();
    sig = 4'b0000; tick();
    check_val("t4_stable_valid", valid, 1);
    check_val("t4_stable_ch", chan, 2);
    check_val("t4_overrun", overrun, 4'b0100);
    check_val("t4_pending", pending, 4'b0100);
    // New overrun in the same cycle as a clear: the set must win.
    sig = 4'b0100; clr_ovr = 1'b1; tick();
    check_val("t4_set_wins", overrun, 4'b0100);
    sig = 4'b0000; clr_ovr = 1'b0; tick();
    clr_ovr = 1'b1; tick();
    clr_ovr = 1'b0;
    check_val("t4_cleared", overrun, 0);
    ready = 1'b1;
    wait_drain("t4");

    // ch0 rising every 2nd cycle with a single ch1 rise: ch1 is the 2nd grant.
`ifdef EDGE_ARB_FALLING_EN
    push_evt(0, 1'b1);
    push_evt(1, 1'b1);
    push_evt(0, 1'b1);
    push_evt(0, 1'b0);
    push_evt(0, 1'b1);
    push_evt(0, 1'b0);
`else
    push_evt(0, 1'b1);
    push_evt(1, 1'b1);
    push_evt(0, 1'b1);
    push_evt(0, 1'b1);
`endif
    for (int d = 0; d < 6; d++) begin
      sig[0] = ((d % 2) == 0);
      if (d == 1) sig[1] = 1'b1;
      tick();
    end
    wait_drain("t5");
    sig[1] = 1'b0;
`ifdef EDGE_ARB_FALLING_EN
    push_evt(1, 1'b0);
`endif
    wait_drain("t5_release");
`ifdef EDGE_ARB_FALLING_EN
    check_val("t5_ovr_fall", overrun, 4'b0001);
`else
    check_val("t5_no_ovr", overrun, 0);
`endif
    clr_ovr = 1'b1; tick();
    clr_ovr = 1'b0;
    check_val("t5_ovr_clr", overrun, 0);

    // Reset in the middle of a held event with another pending.
    ready = 1'b0;
    sig = 4'b1000; tick();
    sig = 4'b1010; tick();
    tick();
    check_val("mr_valid", valid, 1);
    check_val("mr_channel", chan, 3);
    check_val("mr_pending", pending, 4'b0010);
    sig = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_state("mr_rst");
    ready = 1'b1;
    repeat (5) tick();
    check_val("mr_quiet", valid, 0);
    check_val("mr_quiet_pend", pending, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
